// File: rtl/idct4_stream.sv
// 4-point inverse integer DCT (weights 64/83/36) over a serial valid/ready coefficient
// stream; emits four rounded, shifted and saturated samples per block in parallel.
module idct4_stream #(
  parameter int WIDTH_X = 16,
  parameter int WIDTH_Y = 16,
  parameter int SHIFT   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_X-1:0] in_coef,
  input  logic                      in_first,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_Y-1:0] x0,
  output logic signed [WIDTH_Y-1:0] x1,
  output logic signed [WIDTH_Y-1:0] x2,
  output logic signed [WIDTH_Y-1:0] x3,
  output logic                      out_sat,
  output logic                      sync_err
);

  localparam int BW = WIDTH_X + 8;
  localparam int VW = WIDTH_X + 9;
  localparam logic signed [VW-1:0] RND  = VW'(1) <<< (SHIFT - 1);
  localparam logic signed [VW-1:0] YMAX = (VW'(1) <<< (WIDTH_Y - 1)) - VW'(1);
  localparam logic signed [VW-1:0] YMIN = -YMAX - VW'(1);

  function automatic logic signed [BW-1:0] mul64(input logic signed [BW-1:0] a);
    return a <<< 6;
  endfunction

  function automatic logic signed [BW-1:0] mul83(input logic signed [BW-1:0] a);
    return (a <<< 6) + (a <<< 4) + (a <<< 1) + a;
  endfunction

  function automatic logic signed [BW-1:0] mul36(input logic signed [BW-1:0] a);
    return (a <<< 5) + (a <<< 2);
  endfunction

  function automatic logic signed [VW-1:0] widen(input logic signed [BW-1:0] a);
    return {a[BW-1], a};
  endfunction

  // Returns {clipped, sample}: round half up, floor shift, clip to the output range.
  function automatic logic [WIDTH_Y:0] round_sat(input logic signed [VW-1:0] v);
    logic signed [VW-1:0] r;
    r = (v + RND) >>> SHIFT;
    if (r > YMAX) return {1'b1, YMAX[WIDTH_Y-1:0]};
    if (r < YMIN) return {1'b1, YMIN[WIDTH_Y-1:0]};
    return {1'b0, r[WIDTH_Y-1:0]};
  endfunction

  logic [1:0]                cnt;
  logic signed [WIDTH_X-1:0] c_p0 [4];
  logic                      vld_p0;
  logic signed [BW-1:0]      s_p0 [4];
  logic signed [BW-1:0]      e0_p1, e1_p1, o0_p1, o1_p1;
  logic                      vld_p1;
  logic signed [VW-1:0]      v0, v1, v2, v3;
  logic [WIDTH_Y:0]          rs0, rs1, rs2, rs3;
  logic                      a2b, b2c, accept, resync;

  assign b2c      = vld_p1 && (!out_valid || out_ready);
  assign a2b      = vld_p0 && (!vld_p1 || b2c);
  assign in_ready = !rst && (!vld_p0 || a2b);
  assign accept   = in_valid && in_ready;
  assign resync   = accept && in_first && (cnt != 2'd0);

  // Stage A: serial collector. A full block waits here until stage B frees up;
  // the next block's c0 may land in the same cycle the full block moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      vld_p0   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= resync;
      if (a2b) vld_p0 <= 1'b0;
      if (accept) begin
        if (resync) begin
          cnt <= 2'd1;
        end else begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) vld_p0 <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) c_p0[resync ? 2'd0 : cnt] <= in_coef;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) s_p0[i] = {{8{c_p0[i][WIDTH_X-1]}}, c_p0[i]};
  end

  // Stage B: even/odd butterfly halves.
  always_ff @(posedge clk) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (a2b) vld_p1 <= 1'b1;
    else if (b2c) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (a2b) begin
      e0_p1 <= mul64(s_p0[0] + s_p0[2]);
      e1_p1 <= mul64(s_p0[0] - s_p0[2]);
      o0_p1 <= mul83(s_p0[1]) + mul36(s_p0[3]);
      o1_p1 <= mul36(s_p0[1]) - mul83(s_p0[3]);
    end
  end

  always_comb begin
    v0  = widen(e0_p1) + widen(o0_p1);
    v1  = widen(e1_p1) + widen(o1_p1);
    v2  = widen(e1_p1) - widen(o1_p1);
    v3  = widen(e0_p1) - widen(o0_p1);
    rs0 = round_sat(v0);
    rs1 = round_sat(v1);
    rs2 = round_sat(v2);
    rs3 = round_sat(v3);
  end

  // Stage C: output register, held bit-stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      out_sat   <= 1'b0;
    end else if (b2c) begin
      out_valid <= 1'b1;
      x0        <= rs0[WIDTH_Y-1:0];
      x1        <= rs1[WIDTH_Y-1:0];
      x2        <= rs2[WIDTH_Y-1:0];
      x3        <= rs3[WIDTH_Y-1:0];
      out_sat   <= rs0[WIDTH_Y] | rs1[WIDTH_Y] | rs2[WIDTH_Y] | rs3[WIDTH_Y];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idct4_stream.sv
// Scoreboard bench for idct4_stream: directed cases plus randomized blocks with
// random gaps, resyncs and backpressure, checked against an integer reference model.
module tb_idct4_stream;

  localparam int WX = 16;
  localparam int WY = 16;
  localparam int SH = 7;

  typedef struct packed {
    logic signed [WY-1:0] x0, x1, x2, x3;
    logic                 sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [WX-1:0] in_coef = '0;
  logic                 in_first = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [WY-1:0] x0, x1, x2, x3;
  logic                 out_sat;
  logic                 sync_err;

  idct4_stream #(.WIDTH_X(WX), .WIDTH_Y(WY), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_coef(in_coef), .in_first(in_first), .out_valid(out_valid),
    .out_ready(out_ready), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_sat(out_sat), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   part[$];
  int   sync_exp = 0;
  int   sync_seen = 0;
  bit   rand_bp = 1'b0;
  exp_t last_got = '0;

  function automatic exp_t ref_block(int c0, int c1, int c2, int c3);
    longint e0, e1, o0, o1;
    longint v[4];
    longint y;
    exp_t   r;
    logic signed [WY-1:0] xs[4];
    bit     sat;
    e0 = 64 * (longint'(c0) + c2);
    e1 = 64 * (longint'(c0) - c2);
    o0 = 83 * longint'(c1) + 36 * longint'(c3);
    o1 = 36 * longint'(c1) - 83 * longint'(c3);
    v[0] = e0 + o0; v[1] = e1 + o1; v[2] = e1 - o1; v[3] = e0 - o0;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y = (v[i] + (longint'(1) <<< (SH - 1))) >>> SH;
      if (y > 32767)  begin y = 32767;  sat = 1'b1; end
      if (y < -32768) begin y = -32768; sat = 1'b1; end
      xs[i] = WY'(y);
    end
    r.x0 = xs[0]; r.x1 = xs[1]; r.x2 = xs[2]; r.x3 = xs[3]; r.sat = sat;
    return r;
  endfunction

  function automatic void model_accept(int v, bit f);
    if (f && part.size() != 0) begin
      part.delete();
      sync_exp++;
    end
    part.push_back(v);
    if (part.size() == 4) begin
      sb.push_back(ref_block(part[0], part[1], part[2], part[3]));
      part.delete();
    end
  endfunction

  // Monitor: pops on each output handshake and checks hold-stability under stall.
  initial begin
    bit   stall;
    exp_t held, got, e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      got = {x0, x1, x2, x3, out_sat};
      if (sync_err) sync_seen++;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (!out_valid || got != held) begin
            errors++;
            $display("FAIL hold: got v=%0b %0d %0d %0d %0d s=%0b, required v=1 %0d %0d %0d %0d s=%0b",
                     out_valid, x0, x1, x2, x3, out_sat, held.x0, held.x1, held.x2, held.x3, held.sat);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          last_got = got;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %0d %0d %0d %0d s=%0b, required no output",
                     x0, x1, x2, x3, out_sat);
          end else begin
            e = sb.pop_front();
            if (got != e) begin
              errors++;
              $display("FAIL output: got %0d %0d %0d %0d s=%0b, required %0d %0d %0d %0d s=%0b",
                       x0, x1, x2, x3, out_sat, e.x0, e.x1, e.x2, e.x3, e.sat);
            end
          end
        end
        stall = out_valid && !out_ready;
        held  = got;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_beat(int v, bit f);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_coef  = WX'(v);
    in_first = f;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
        in_valid = 1'b0;
        return;
      end
      step();
    end
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    model_accept(v, f);
  endtask

  task automatic send_block(int c0, int c1, int c2, int c3);
    send_beat(c0, 1'b1);
    send_beat(c1, 1'b0);
    send_beat(c2, 1'b0);
    send_beat(c3, 1'b0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && w < 1000) begin
      step();
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d blocks outstanding, required 0", sb.size());
    end
    idle(3);
  endtask

  task automatic check_last(string name, int e0, int e1, int e2, int e3, bit es);
    checks++;
    if (last_got.x0 != WY'(e0) || last_got.x1 != WY'(e1) || last_got.x2 != WY'(e2) ||
        last_got.x3 != WY'(e3) || last_got.sat != es) begin
      errors++;
      $display("FAIL %s: got %0d %0d %0d %0d s=%0b, required %0d %0d %0d %0d s=%0b", name,
               last_got.x0, last_got.x1, last_got.x2, last_got.x3, last_got.sat, e0, e1, e2, e3, es);
    end
  endtask

  // DC block at full rate; out_valid pattern over the three cycles after the 4th beat.
  task automatic check_latency(string name);
    logic [2:0] seen;
    send_beat(64, 1'b1);
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen[i] = out_valid;
    end
    checks++;
    if (seen != 3'b100) begin
      errors++;
      $display("FAIL %s: got out_valid pattern %03b, required 100", name, seen);
    end
    step();
    drain();
    check_last(name, 32, 32, 32, 32, 1'b0);
  endtask

  initial begin
    int nvalid;
    logic signed [WX-1:0] t;
    int c[4];

    // Reset state
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sync_err !== 1'b0 || out_sat !== 1'b0 ||
        x0 !== '0 || x1 !== '0 || x2 !== '0 || x3 !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b se=%b sat=%b x=%0d %0d %0d %0d, required all 0",
               out_valid, in_ready, sync_err, out_sat, x0, x1, x2, x3);
    end
    step();
    rst = 1'b0;
    step();

    // 1 DC with latency, 2 odd, 3 saturation
    check_latency("dc_latency");
    send_block(0, 64, 0, 0);
    drain();
    check_last("odd", 42, 18, -18, -41, 1'b0);
    send_block(32767, 32767, 0, 0);
    drain();
    check_last("saturation", 32767, 25599, 7168, -4864, 1'b1);

    // 4 Backpressure: three blocks fill A/B/C, the fourth must stall at c0
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) send_block(100 * (b + 1), -50 * b, 7 * b, 300 - b);
    in_valid = 1'b1;
    in_coef  = WX'(1234);
    in_first = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) nvalid++;
      step();
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL bp_stall: got in_ready=1 on %0d cycles, required 0", nvalid);
    end
    out_ready = 1'b1;
    send_block(1234, -999, 555, -32768);
    drain();

    // 5 Resync: partial block discarded
    send_beat(10, 1'b1);
    send_beat(20, 1'b0);
    send_beat(64, 1'b1);
    @(negedge clk);
    checks++;
    if (sync_err !== 1'b1) begin
      errors++;
      $display("FAIL resync_pulse: got sync_err=%b, required 1", sync_err);
    end
    step();
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    drain();
    check_last("resync", 32, 32, 32, 32, 1'b0);

    // 6 Reset with two blocks in flight and two beats in A
    out_ready = 1'b0;
    send_block(500, 600, 700, 800);
    send_block(-500, 60, -70, 8);
    send_beat(11, 1'b1);
    send_beat(22, 1'b0);
    rst = 1'b1;
    sb.delete();
    part.delete();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b, required 0", in_ready);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
      step();
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL reset_flush: got out_valid on %0d cycles, required 0", nvalid);
    end
    check_latency("post_reset_latency");

    // Randomized blocks with gaps, occasional resyncs and random backpressure
    rand_bp = 1'b1;
    for (int b = 0; b < 80; b++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          t = WX'($urandom);
          send_beat(int'(t), k == 0);
        end
      end
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: c[k] = int'($urandom_range(0, 400)) - 200;
          1: c[k] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
          default: begin t = WX'($urandom); c[k] = int'(t); end
        endcase
      end
      send_beat(c[0], ($urandom_range(0, 1) != 0));
      for (int k = 1; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        send_beat(c[k], 1'b0);
      end
    end
    drain();

    checks++;
    if (sync_seen != sync_exp) begin
      errors++;
      $display("FAIL sync_err_count: got %0d pulse cycles, required %0d", sync_seen, sync_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
